// File: rtl/chiplet_types_pkg.sv
// Shared chiplet types: flit layout, node/packet ids, header length decode
// and the TX sequencer state encoding.
package chiplet_types_pkg;

    localparam int NODE_ID_WIDTH    = 4;
    localparam int PKT_ID_WIDTH     = 4;
    localparam int VC_FIELD_WIDTH   = 2;
    localparam int PKT_LENGTH_WIDTH = 8;

    typedef logic [NODE_ID_WIDTH-1:0]  node_id_t;
    typedef logic [PKT_ID_WIDTH-1:0]   pkt_id_t;
    typedef logic [VC_FIELD_WIDTH-1:0] vc_id_t;

    typedef struct packed {
        vc_id_t      vc;
        pkt_id_t     id;
        node_id_t    req;
        logic [31:0] payload;
    } flit_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FETCH_HDR = 2'd1,
        ST_SEND      = 2'd2,
        ST_DONE      = 2'd3
    } tx_seq_state_e;

    // Total flit count of a packet, header word included, from its header.
    function automatic logic [PKT_LENGTH_WIDTH-1:0] expected_num_flits(input logic [31:0] hdr);
        return hdr[PKT_LENGTH_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/tx_seq_arbiter.sv
// Slot arbiter for the TX sequencer: round-robin by default, fixed priority
// (lowest index wins) when TX_SEQ_FIXED_PRIO_EN is defined.
module tx_seq_arbiter
    import chiplet_types_pkg::*;
#(
    parameter  int NUM_MSGS = 4,
    localparam int IDX_W    = $clog2(NUM_MSGS)
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NUM_MSGS-1:0] i_req,
    input  logic                i_gnt_en,
    output logic [NUM_MSGS-1:0] o_gnt,
    output logic [IDX_W-1:0]    o_gnt_idx
);

    logic w_found;

`ifdef TX_SEQ_FIXED_PRIO_EN

    always_comb begin
        w_found   = 1'b0;
        o_gnt_idx = '0;
        o_gnt     = '0;
        for (int i = 0; i < NUM_MSGS; i++) begin
            if (i_req[i] && !w_found) begin
                w_found   = 1'b1;
                o_gnt_idx = IDX_W'(i);
            end
        end
        if (w_found && i_gnt_en) begin
            o_gnt[o_gnt_idx] = 1'b1;
        end
    end

`else

    logic [IDX_W-1:0] r_ptr;
    int               w_j;

    // Search starts at r_ptr and wraps, so the slot after the last grant leads.
    always_comb begin
        w_found   = 1'b0;
        o_gnt_idx = '0;
        o_gnt     = '0;
        w_j       = 0;
        for (int off = 0; off < NUM_MSGS; off++) begin
            w_j = int'(r_ptr) + off;
            if (w_j >= NUM_MSGS) begin
                w_j = w_j - NUM_MSGS;
            end
            if (i_req[w_j] && !w_found) begin
                w_found   = 1'b1;
                o_gnt_idx = IDX_W'(w_j);
            end
        end
        if (w_found && i_gnt_en) begin
            o_gnt[o_gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_ptr <= '0;
        end else if (i_gnt_en && w_found) begin
            if (o_gnt_idx == IDX_W'(NUM_MSGS - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= o_gnt_idx + 1'b1;
            end
        end
    end

`endif

endmodule

// File: rtl/tx_pkt_sequencer.sv
// Multi-slot, multi-VC packet transmit engine: arbitrates queued sends, reads
// packet words over a stallable bus and emits credit-gated flits. Arbiter
// policy is selected by TX_SEQ_FIXED_PRIO_EN (see tx_seq_arbiter).
module tx_pkt_sequencer
    import chiplet_types_pkg::*;
#(
    parameter  int NUM_MSGS = 4,
    parameter  int NUM_VCS  = 2,
    parameter  int DEPTH    = 8,
    localparam int VC_W     = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
    localparam int ID_W     = $clog2(NUM_MSGS),
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  node_id_t                 node_id,
    input  logic [NUM_MSGS-1:0]      trigger_send,
    input  logic [NUM_MSGS*32-1:0]   pkt_start_addr,
    input  logic [NUM_MSGS*VC_W-1:0] pkt_vc,
    output logic [NUM_MSGS-1:0]      send_done,
    output logic                     busy,
    output logic                     bus_ren,
    output logic [31:0]              bus_addr,
    input  logic [31:0]              bus_rdata,
    input  logic                     bus_stall,
    output flit_t                    flit_out,
    output logic                     flit_valid,
    input  logic [NUM_VCS-1:0]       credit_in,
    output logic [1:0]               o_dbg_state,
    output logic [NUM_VCS*CW-1:0]    o_dbg_credits
);

    tx_seq_state_e               r_state;
    tx_seq_state_e               w_next_state;
    logic [NUM_MSGS-1:0]         r_pending;
    logic [ID_W-1:0]             r_cur_id;
    logic [VC_W-1:0]             r_cur_vc;
    logic [31:0]                 r_cur_addr;
    logic [PKT_LENGTH_WIDTH-1:0] r_cur_len;
    logic [PKT_LENGTH_WIDTH-1:0] r_count;
    logic [CW-1:0]               r_credits [NUM_VCS];

    logic [NUM_MSGS-1:0]         w_gnt;
    logic [ID_W-1:0]             w_gnt_idx;
    logic                        w_gnt_en;
    logic                        w_credit_ok;
    logic                        w_last;
    logic [PKT_LENGTH_WIDTH-1:0] w_hdr_len;
    logic [NUM_VCS-1:0]          w_cred_take;

    assign w_gnt_en    = (r_state == ST_IDLE);
    assign w_credit_ok = (r_credits[r_cur_vc] != '0);
    assign w_last      = (r_count == r_cur_len - 1'b1);
    assign w_hdr_len   = expected_num_flits(bus_rdata);
    assign busy        = (r_state != ST_IDLE) || (|r_pending);
    assign o_dbg_state = r_state;

    tx_seq_arbiter #(
        .NUM_MSGS (NUM_MSGS)
    ) u_arb (
        .clk       (clk),
        .n_rst     (n_rst),
        .i_req     (r_pending),
        .i_gnt_en  (w_gnt_en),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:      if (|r_pending) w_next_state = ST_FETCH_HDR;
            ST_FETCH_HDR: if (!bus_stall) w_next_state = ST_SEND;
            ST_SEND:      if (flit_valid && w_last) w_next_state = ST_DONE;
            ST_DONE:      w_next_state = ST_IDLE;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    // Bus handshake: a read completes in any cycle with bus_ren && !bus_stall;
    // while stalled, bus_ren and bus_addr are held unchanged.
    always_comb begin
        bus_ren    = 1'b0;
        bus_addr   = '0;
        flit_valid = 1'b0;
        flit_out   = '0;
        send_done  = '0;
        case (r_state)
            ST_FETCH_HDR: begin
                bus_ren  = 1'b1;
                bus_addr = r_cur_addr;
            end
            ST_SEND: begin
                bus_ren    = w_credit_ok && (r_count < r_cur_len);
                bus_addr   = r_cur_addr + 32'({r_count, 2'b00});
                flit_valid = bus_ren && !bus_stall;
                if (flit_valid) begin
                    flit_out.vc      = vc_id_t'(r_cur_vc);
                    flit_out.id      = pkt_id_t'(r_cur_id);
                    flit_out.req     = node_id;
                    flit_out.payload = bus_rdata;
                end
            end
            ST_DONE: send_done[r_cur_id] = 1'b1;
            default: ;
        endcase
    end

    // A trigger in the grant cycle wins, so the active slot is queued again.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_gnt) | trigger_send;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cur_id   <= '0;
            r_cur_vc   <= '0;
            r_cur_addr <= '0;
            r_cur_len  <= '0;
            r_count    <= '0;
        end else begin
            if (r_state == ST_IDLE && (|r_pending)) begin
                r_cur_id   <= w_gnt_idx;
                r_cur_vc   <= pkt_vc[w_gnt_idx*VC_W +: VC_W];
                r_cur_addr <= pkt_start_addr[w_gnt_idx*32 +: 32];
            end
            if (r_state == ST_FETCH_HDR && !bus_stall) begin
                r_cur_len <= (w_hdr_len == '0) ? PKT_LENGTH_WIDTH'(1) : w_hdr_len;
                r_count   <= '0;
            end
            if (flit_valid) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    always_comb begin
        for (int v = 0; v < NUM_VCS; v++) begin
            w_cred_take[v] = flit_valid && (r_cur_vc == VC_W'(v));
            o_dbg_credits[v*CW +: CW] = r_credits[v];
        end
    end

    // Send and return on one VC cancel; returns at DEPTH saturate.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                r_credits[v] <= CW'(DEPTH);
            end
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                if (w_cred_take[v] && !credit_in[v]) begin
                    r_credits[v] <= r_credits[v] - 1'b1;
                end else if (!w_cred_take[v] && credit_in[v] && (r_credits[v] != CW'(DEPTH))) begin
                    r_credits[v] <= r_credits[v] + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/tx_pkt_sequencer.md
# tx_pkt_sequencer

Multi-slot, multi-VC packet transmit engine for the chiplet endpoint. It holds up to NUM_MSGS queued send requests and picks one at a time by arbitration. For the chosen packet it reads the words from the TX packet buffer over a stallable bus and emits one flit per word into switch port 0. Flits are only sent when the downstream buffer of the packet's virtual channel has a free slot, as tracked by per-VC credit counters.

## Interface
Parameters:
- NUM_MSGS, 4, number of message slots (packet IDs); ≥2
- NUM_VCS, 2, virtual channels; ≥1
- DEPTH, 8, downstream buffer depth per VC; this is the initial credit count

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- node_id  in  node_id_t  source node stamped into flit.req
- trigger_send  in  NUM_MSGS  one-cycle request pulse per slot
- pkt_start_addr  in  NUM_MSGS×32  byte address of the header word for each slot
- pkt_vc  in  NUM_MSGS×VC_W  VC for each slot; VC_W = max(1,$clog2(NUM_VCS))
- send_done  out  NUM_MSGS  one-cycle completion pulse per slot
- busy  out  1  high when state ≠ IDLE or any slot is pending
- bus_ren  out  1  read request
- bus_addr  out  32  read address
- bus_rdata  in  32  read data; valid when bus_ren && !bus_stall
- bus_stall  in  1  bus not ready this cycle
- flit_out  out  flit_t  flit to switch
- flit_valid  out  1  flit_out is transferred this cycle; there is no back-pressure beyond credits
- credit_in  in  NUM_VCS  one-cycle credit return per VC

## Operation
- Pending register, NUM_MSGS bits:
  - Set on trigger_send[i].
  - Cleared when slot i is granted.
  - A trigger for an already-pending slot is absorbed.
  - A trigger for the active slot re-sets pending, so the packet is sent again later.
- States: IDLE, FETCH_HDR, SEND, DONE.
- IDLE: if pending ≠ 0, grant a slot via the arbiter and latch cur_id, cur_vc and cur_addr. Go to FETCH_HDR.
- FETCH_HDR: bus_ren=1, bus_addr=cur_addr. On completion, latch cur_len = expected_num_flits(bus_rdata), clear count, go to SEND.
- SEND:
  - bus_ren = (credits[cur_vc] ≠ 0) && count < cur_len.
  - bus_addr = cur_addr + 4·count, 32-bit wrap.
  - On completion: flit_valid=1, flit_out={vc=cur_vc, id=cur_id, req=node_id, payload=bus_rdata}, count++, credits[cur_vc]--.
  - When the last flit (count = cur_len−1) completes, go to DONE.
- DONE: send_done[cur_id]=1 for one cycle, then go to IDLE.
- Credits: one counter per VC, width $clog2(DEPTH+1), reset to DEPTH.
  - Send and credit_in on the same VC in the same cycle: counter unchanged.
  - credit_in arriving while the counter is at DEPTH is ignored (saturate).
- cur_len is PKT_LENGTH_WIDTH wide. A header that decodes to length 0 is treated as 1.
- When flit_valid=0, flit_out is all zero.

## Timing
- All outputs reset to 0. Credits reset to DEPTH, state to IDLE, pending to 0.
- Asynchronous reset mid-packet abandons the packet. No send_done is issued.
- With no stalls and ample credits, a trigger at cycle 0 produces:
  - pending set at cycle 1
  - grant at cycle 1, FETCH_HDR at cycle 2
  - flit k at cycle 3+k
  - send_done at cycle 3+L (L = packet length)
- Each bus_stall cycle delays only that read; bus_addr and bus_ren are held.
- At zero credits, bus_ren drops. It reasserts the cycle after a credit is returned.
- Throughput: 1 flit/cycle sustained. There is a 3-cycle gap between packets (DONE, IDLE, FETCH_HDR).

## Configuration
- TX_SEQ_FIXED_PRIO_EN defined: the arbiter is fixed-priority, lowest pending index wins.
- Not defined: the arbiter is round-robin. The pointer advances to the slot after the last grant.

## Structure
- chiplet_types_pkg holds flit_t, node_id_t, pkt_id_t, PKT_LENGTH_WIDTH and expected_num_flits(). Add a tx_seq_state_e enum there.
- Sub-module tx_seq_arbiter, parametrised by NUM_MSGS. Inputs: request vector and grant enable. Outputs: one-hot grant and index. It contains the macro-selected policy.

## Test plan
- Slot 0, header decodes to 3 flits, no stalls, VC0 → flits at cycles 3, 4, 5 with addresses base, base+4, base+8, id=0; send_done[0] at cycle 6.
- DEPTH=2, 4-flit packet, no credit returns → 2 flits sent, then bus_ren=0 and the FSM holds; a credit_in[0] pulse → 3rd flit follows 1 cycle later.
- trigger_send=4'b1011 in one cycle:
  - Round-robin: order 0, 1, 3.
  - With TX_SEQ_FIXED_PRIO_EN, retriggering slot 0 during slot 1's packet → order 0, 1, 0, 3.
- bus_stall high for 2 cycles on flit 1 → flit 1 delayed 2 cycles with address held; total flit count unchanged.
- Simultaneous send and credit_in on the same VC → credit count constant; credit_in while credits=DEPTH → stays at DEPTH.
- n_rst asserted mid-SEND → all outputs 0 and credits=DEPTH; no send_done; a fresh trigger works normally afterwards.
